// File: rtl/match_qualifier.sv
// Debounces the comparator Q output: a match is qualified after STABLE_CYCLES
// consecutive enabled high samples, with a saturating match counter and sticky overflow.
// Optional QUALIFIER_SYNC_EN adds a two-flop synchronizer on q_in.
module match_qualifier #(
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             q_in,
  input  logic             clr_cnt,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_ovf,
  output logic             busy
);

  localparam int SW = ($clog2(STABLE_CYCLES + 1) > 1) ? $clog2(STABLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    HIT      = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [SW-1:0]    stab_cnt_r;
  logic [SW-1:0]    stab_nxt_s;
  logic             q_smp_s;
  logic             inc_s;
  logic             pulse_nxt_s;
  logic             match_pulse_r;
  logic [CNT_W-1:0] match_cnt_r;
  logic             cnt_ovf_r;
  logic             busy_r;

`ifdef QUALIFIER_SYNC_EN
  logic q_meta_r;
  logic q_sync_r;

  // Two-flop synchronizer for an asynchronous comparator output
  always_ff @(posedge clk) begin
    if (rst) begin
      q_meta_r <= 1'b0;
      q_sync_r <= 1'b0;
    end else begin
      q_meta_r <= q_in;
      q_sync_r <= q_meta_r;
    end
  end

  assign q_smp_s = q_sync_r;
`else
  assign q_smp_s = q_in;
`endif

  // State and stability-count register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      stab_cnt_r <= {SW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      stab_cnt_r <= stab_nxt_s;
    end
  end

  // Next-state logic; en low always returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    stab_nxt_s  = stab_cnt_r;
    if (!en) begin
      state_nxt_s = IDLE;
      stab_nxt_s  = {SW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (q_smp_s && (STABLE_CYCLES == 1)) begin
            state_nxt_s = HIT;
            stab_nxt_s  = {SW{1'b0}};
          end else if (q_smp_s) begin
            state_nxt_s = QUAL;
            stab_nxt_s  = SW'(1);
          end else begin
            state_nxt_s = IDLE;
            stab_nxt_s  = {SW{1'b0}};
          end
        end
        QUAL: begin
          if (!q_smp_s) begin
            state_nxt_s = IDLE;
            stab_nxt_s  = {SW{1'b0}};
          end else if (stab_cnt_r == SW'(STABLE_CYCLES - 1)) begin
            state_nxt_s = HIT;
            stab_nxt_s  = {SW{1'b0}};
          end else begin
            state_nxt_s = QUAL;
            stab_nxt_s  = stab_cnt_r + SW'(1);
          end
        end
        HIT: begin
          stab_nxt_s = {SW{1'b0}};
          if (q_smp_s) begin
            state_nxt_s = WAIT_LOW;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        WAIT_LOW: begin
          stab_nxt_s = {SW{1'b0}};
          if (q_smp_s) begin
            state_nxt_s = WAIT_LOW;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          stab_nxt_s  = {SW{1'b0}};
        end
      endcase
    end
  end

  // Output decode: HIT is entered only from IDLE/QUAL, so entry equals next-state HIT
  always_comb begin
    if (state_nxt_s == HIT) begin
      inc_s       = 1'b1;
      pulse_nxt_s = 1'b1;
    end else begin
      inc_s       = 1'b0;
      pulse_nxt_s = 1'b0;
    end
  end

  // Registered pulse and busy, aligned with the state register
  always_ff @(posedge clk) begin
    if (rst) begin
      match_pulse_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      match_pulse_r <= pulse_nxt_s;
      busy_r        <= (state_nxt_s != IDLE);
    end
  end

  // Saturating match counter; clear wins but still counts a coincident hit
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt_r <= {CNT_W{1'b0}};
      cnt_ovf_r   <= 1'b0;
    end else if (clr_cnt) begin
      match_cnt_r <= inc_s ? CNT_W'(1) : {CNT_W{1'b0}};
      cnt_ovf_r   <= 1'b0;
    end else if (inc_s) begin
      if (&match_cnt_r) begin
        match_cnt_r <= match_cnt_r;
        cnt_ovf_r   <= 1'b1;
      end else begin
        match_cnt_r <= match_cnt_r + CNT_W'(1);
        cnt_ovf_r   <= cnt_ovf_r;
      end
    end else begin
      match_cnt_r <= match_cnt_r;
      cnt_ovf_r   <= cnt_ovf_r;
    end
  end

  assign match_pulse = match_pulse_r;
  assign match_cnt   = match_cnt_r;
  assign cnt_ovf     = cnt_ovf_r;
  assign busy        = busy_r;

endmodule
